// File: rtl/oh_elastic_buffer.sv
// Registered elastic FIFO between two valid/ready interfaces in one clock domain.
// Every output comes from a flop, so no combinational path crosses the buffer.
module oh_elastic_buffer #(
  parameter int N     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [N-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;

  // Handshakes qualify only against registered flags, which keeps ready/valid
  // isolated from the opposite side.
  always_comb begin
    push = in_valid & ~full_q & ~reset;
    pop  = out_ready & ~empty_q & ~reset;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
    full_q   <= full_d;
    empty_q  <= empty_d;
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    in_ready  = ~full_q;
    out_valid = ~empty_q;
    out_data  = mem_q[rd_ptr_q];
    count     = count_q;
    full      = full_q;
    empty     = empty_q;
  end

  a_in_hold: assert property (@(posedge clk) disable iff (reset)
    (in_valid && !in_ready) |=> (!in_valid || $stable(in_data)));

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    (count_q <= CW'(DEPTH)));

endmodule

// File: tb/tb_oh_elastic_buffer.sv
// Bench for oh_elastic_buffer: directed scenarios on a 32x4 instance and
// randomized backpressure on an 8x8 instance, both against queue models.
module tb_oh_elastic_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=32, DEPTH=4
  logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_full, a_empty;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_count;

  // Instance B: N=8, DEPTH=8
  logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_full, b_empty;
  logic [7:0]  b_in_data, b_out_data;
  logic [3:0]  b_count;

  oh_elastic_buffer #(.N(32), .DEPTH(4)) u_dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(a_out_ready), .count(a_count), .full(a_full), .empty(a_empty));

  oh_elastic_buffer #(.N(8), .DEPTH(8)) u_dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_ready(b_out_ready), .count(b_count), .full(b_full), .empty(b_empty));

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] qa[$];
  logic [7:0]  qb[$];
  int a_push_obs, a_pop_obs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // One cycle on A: check outputs against the model, drive, advance model at the edge.
  task automatic step_a(input logic rst_i, input logic v, input logic [31:0] d, input logic rdy);
    logic do_push, do_pop;
    int sz;
    sz = qa.size();
    chk("a_count", 64'(a_count), 64'(sz));
    chk("a_empty", 64'(a_empty), 64'(sz == 0));
    chk("a_full", 64'(a_full), 64'(sz == 4));
    chk("a_in_ready", 64'(a_in_ready), 64'(sz < 4));
    chk("a_out_valid", 64'(a_out_valid), 64'(sz > 0));
    if (sz > 0) chk("a_out_data", 64'(a_out_data), 64'(qa[0]));
    a_reset = rst_i; a_in_valid = v; a_in_data = d; a_out_ready = rdy;
    do_push = !rst_i && v && (sz < 4);
    do_pop  = !rst_i && rdy && (sz > 0);
    if (!rst_i && v && a_in_ready) a_push_obs++;
    if (!rst_i && rdy && a_out_valid) a_pop_obs++;
    @(posedge clk);
    if (rst_i) qa.delete();
    else begin
      if (do_pop) void'(qa.pop_front());
      if (do_push) qa.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic step_b(input logic rst_i, input logic v, input logic [7:0] d, input logic rdy);
    logic do_push, do_pop;
    int sz;
    sz = qb.size();
    chk("b_count", 64'(b_count), 64'(sz));
    chk("b_empty", 64'(b_empty), 64'(sz == 0));
    chk("b_full", 64'(b_full), 64'(sz == 8));
    chk("b_in_ready", 64'(b_in_ready), 64'(sz < 8));
    chk("b_out_valid", 64'(b_out_valid), 64'(sz > 0));
    if (sz > 0) chk("b_out_data", 64'(b_out_data), 64'(qb[0]));
    b_reset = rst_i; b_in_valid = v; b_in_data = d; b_out_ready = rdy;
    do_push = !rst_i && v && (sz < 8);
    do_pop  = !rst_i && rdy && (sz > 0);
    @(posedge clk);
    if (rst_i) qb.delete();
    else begin
      if (do_pop) void'(qb.pop_front());
      if (do_push) qb.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    int idx;
    logic [31:0] word;
    logic [7:0]  bword;
    logic        bv;

    a_reset = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset / idle
    step_a(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step_a(1'b0, 1'b0, 32'h0, 1'b0);

    // Streaming
    a_push_obs = 0; a_pop_obs = 0;
    for (int i = 1; i <= 100; i++) step_a(1'b0, 1'b1, 32'(i), 1'b1);
    repeat (3) step_a(1'b0, 1'b0, 32'h0, 1'b1);
    chk("stream_pushes", 64'(a_push_obs), 64'd100);
    chk("stream_pops", 64'(a_pop_obs), 64'd100);

    // Fill then drain, offering 0xA0..0xA5
    a_push_obs = 0; a_pop_obs = 0; idx = 0;
    for (int c = 0; c < 6; c++) begin
      word = 32'hA0 + 32'(idx);
      if (a_in_ready) idx++;
      step_a(1'b0, 1'b1, word, 1'b0);
    end
    chk("fill_accepted", 64'(idx), 64'd4);
    chk("fill_full", 64'(a_full), 64'd1);
    chk("fill_count", 64'(a_count), 64'd4);
    for (int c = 0; c < 20 && (idx < 6 || !a_empty); c++) begin
      word = 32'hA0 + 32'(idx);
      if (idx < 6 && a_in_ready) begin
        step_a(1'b0, 1'b1, word, 1'b1);
        idx++;
      end else step_a(1'b0, idx < 6, word, 1'b1);
    end
    chk("drain_accepted", 64'(idx), 64'd6);
    chk("drain_pops", 64'(a_pop_obs), 64'd6);
    chk("drain_empty", 64'(a_empty), 64'd1);

    // Simultaneous push/pop at full, several pointer laps
    for (int i = 0; i < 4; i++) step_a(1'b0, 1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    chk("sim_full", 64'(a_full), 64'd1);
    idx = 4;
    for (int c = 0; c < 18; c++) begin
      word = 32'hB000_0000 + 32'(idx);
      if (a_in_ready) idx++;
      step_a(1'b0, 1'b1, word, 1'b1);
    end
    chk("sim_laps", 64'(idx > 16), 64'd1);
    repeat (4) step_a(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-operation with a concurrent push and pop
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 32'hC0 + 32'(i), 1'b0);
    chk("mid_count", 64'(a_count), 64'd3);
    step_a(1'b1, 1'b1, 32'h55, 1'b1);
    chk("post_rst_count", 64'(a_count), 64'd0);
    chk("post_rst_valid", 64'(a_out_valid), 64'd0);
    chk("post_rst_ready", 64'(a_in_ready), 64'd1);
    repeat (3) step_a(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step_a(1'b0, 1'b1, 32'hD0 + 32'(i), 1'b1);
    repeat (4) step_a(1'b0, 1'b0, 32'h0, 1'b1);

    // Random backpressure on the 8-deep instance
    step_b(1'b1, 1'b0, 8'h0, 1'b0);
    bword = 8'($urandom);
    for (int c = 0; c < 10000; c++) begin
      bv = 1'($urandom);
      if (bv && b_in_ready) begin
        step_b(1'b0, 1'b1, bword, 1'($urandom));
        bword = 8'($urandom);
      end else step_b(1'b0, bv, bword, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
